// File: rtl/bram_alu_sweep_ctrl_if.sv
// BRAM port A and ALU operand bundle between the sweep controller and its datapath.
interface bram_alu_sweep_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ALU_OP_W   = 8
);
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  we_a;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [ALU_OP_W-1:0]   alu_opcode;
  logic                  alu_cin;
  logic [DATA_WIDTH-1:0] alu_out;

  modport master (
    output addr_a, data_a, we_a, alu_a, alu_b, alu_opcode, alu_cin,
    input  q_a, alu_out
  );

  modport slave (
    input  addr_a, data_a, we_a, alu_a, alu_b, alu_opcode, alu_cin,
    output q_a, alu_out
  );
endinterface

// File: rtl/bram_alu_sweep_ctrl.sv
// Applies one ALU op with an immediate across a block of BRAM words:
// read, modify, write back, read back and verify, six cycles per word.
module bram_alu_sweep_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ALU_OP_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     count,
  input  logic [ALU_OP_W-1:0]     op_sel,
  input  logic [DATA_WIDTH-1:0]   imm,
  input  logic                    cin_sel,
  input  logic                    stop_on_err,
  bram_alu_sweep_ctrl_if.master   bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [ADDR_WIDTH:0]     words_done,
  output logic [DATA_WIDTH-1:0]   last_result
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_VRD  = 3'd5;
  localparam logic [2:0] S_VCHK = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_reg, base_nxt;
  logic [CNT_W-1:0]      count_reg, count_nxt;
  logic [ALU_OP_W-1:0]   op_sel_reg, op_sel_nxt;
  logic [DATA_WIDTH-1:0] imm_reg, imm_nxt;
  logic                  cin_reg, cin_nxt;
  logic                  stop_reg, stop_nxt;
  logic [CNT_W-1:0]      idx, idx_nxt;
  logic [DATA_WIDTH-1:0] res_reg, res_nxt;

  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  we_q, we_nxt;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_nxt;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_nxt;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_nxt;
  logic                  alu_cin_q, alu_cin_nxt;
  logic                  busy_nxt, done_nxt, error_nxt;
  logic [ADDR_WIDTH-1:0] err_addr_nxt;
  logic [CNT_W-1:0]      words_done_nxt;
  logic [DATA_WIDTH-1:0] last_result_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr_c;
  logic [CNT_W-1:0]      next_idx_c;
  logic                  miscompare_c;

  assign cur_addr_c   = base_reg + ADDR_WIDTH'(idx);
  assign next_idx_c   = idx + CNT_W'(1);
  assign miscompare_c = (bus.q_a != res_reg);

  // Next-state and registered-output values; outputs take effect in the state being entered.
  always_comb begin
    state_nxt       = state;
    base_nxt        = base_reg;
    count_nxt       = count_reg;
    op_sel_nxt      = op_sel_reg;
    imm_nxt         = imm_reg;
    cin_nxt         = cin_reg;
    stop_nxt        = stop_reg;
    idx_nxt         = idx;
    res_nxt         = res_reg;
    addr_nxt        = addr_q;
    data_nxt        = '0;
    we_nxt          = 1'b0;
    alu_a_nxt       = alu_a_q;
    alu_b_nxt       = alu_b_q;
    alu_op_nxt      = alu_op_q;
    alu_cin_nxt     = alu_cin_q;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    error_nxt       = error;
    err_addr_nxt    = err_addr;
    words_done_nxt  = words_done;
    last_result_nxt = last_result;

    case (state)
      S_IDLE: begin
        if (start) begin
          base_nxt       = base_addr;
          count_nxt      = (count > MAX_COUNT) ? MAX_COUNT : count;
          op_sel_nxt     = op_sel;
          imm_nxt        = imm;
          cin_nxt        = cin_sel;
          stop_nxt       = stop_on_err;
          idx_nxt        = '0;
          error_nxt      = 1'b0;
          err_addr_nxt   = '0;
          words_done_nxt = '0;
          busy_nxt       = 1'b1;
          if (count == '0) begin
            state_nxt = S_DONE;
          end else begin
            addr_nxt  = base_addr;
            state_nxt = S_RD;
          end
        end
      end
      S_RD: state_nxt = S_CAP;
      S_CAP: begin
        alu_a_nxt   = bus.q_a;
        alu_b_nxt   = imm_reg;
        alu_op_nxt  = op_sel_reg;
        alu_cin_nxt = cin_reg;
        state_nxt   = S_EXEC;
      end
      S_EXEC: begin
        res_nxt   = bus.alu_out;
        data_nxt  = bus.alu_out;
        we_nxt    = 1'b1;
        state_nxt = S_WR;
      end
      S_WR: begin
        last_result_nxt = res_reg;
        state_nxt       = S_VRD;
      end
      S_VRD: state_nxt = S_VCHK;
      S_VCHK: begin
        if (miscompare_c) begin
          if (!error) err_addr_nxt = cur_addr_c;
          error_nxt = 1'b1;
        end
        words_done_nxt = next_idx_c;
        if ((stop_reg && miscompare_c) || (next_idx_c == count_reg)) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = next_idx_c;
          addr_nxt  = base_reg + ADDR_WIDTH'(next_idx_c);
          state_nxt = S_RD;
        end
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset drops we_a without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base_reg    <= '0;
      count_reg   <= '0;
      op_sel_reg  <= '0;
      imm_reg     <= '0;
      cin_reg     <= 1'b0;
      stop_reg    <= 1'b0;
      idx         <= '0;
      res_reg     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_addr    <= '0;
      words_done  <= '0;
      last_result <= '0;
    end else begin
      state       <= state_nxt;
      base_reg    <= base_nxt;
      count_reg   <= count_nxt;
      op_sel_reg  <= op_sel_nxt;
      imm_reg     <= imm_nxt;
      cin_reg     <= cin_nxt;
      stop_reg    <= stop_nxt;
      idx         <= idx_nxt;
      res_reg     <= res_nxt;
      addr_q      <= addr_nxt;
      data_q      <= data_nxt;
      we_q        <= we_nxt;
      alu_a_q     <= alu_a_nxt;
      alu_b_q     <= alu_b_nxt;
      alu_op_q    <= alu_op_nxt;
      alu_cin_q   <= alu_cin_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      err_addr    <= err_addr_nxt;
      words_done  <= words_done_nxt;
      last_result <= last_result_nxt;
    end
  end

  assign bus.addr_a     = addr_q;
  assign bus.data_a     = data_q;
  assign bus.we_a       = we_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_cin    = alu_cin_q;

endmodule

// File: doc/bram_alu_sweep_ctrl.md
Name: bram_alu_sweep_ctrl

Overview:
- Sequencer that applies one ALU operation across a contiguous block of BRAM words: read, modify with immediate, write back, read back and verify.
- Owns BRAM port A and the ALU operand/opcode inputs while busy, and reports completion and verify errors.
- Sits between the top-level control (switches/buttons or a host FSM) and the BRAM + ALU datapath, replacing single-shot hardwired test sequences.

Parameters:
DATA_WIDTH  16  BRAM word and ALU operand width
ADDR_WIDTH  10  BRAM address width
ALU_OP_W    8   ALU opcode width

Ports:
clk          in   1               system clock, rising edge
rst_n        in   1               asynchronous reset, active-low
start        in   1               pulse; accepted only in IDLE
base_addr    in   ADDR_WIDTH      first word address, sampled on accepted start
count        in   ADDR_WIDTH+1    number of words, sampled on accepted start
op_sel       in   ALU_OP_W        ALU opcode, sampled on accepted start
imm          in   DATA_WIDTH      operand B, sampled on accepted start
cin_sel      in   1               ALU carry-in, sampled on accepted start
stop_on_err  in   1               abort sweep on first miscompare, sampled on accepted start
addr_a       out  ADDR_WIDTH      BRAM port A address
data_a       out  DATA_WIDTH      BRAM port A write data
we_a         out  1               BRAM port A write enable
q_a          in   DATA_WIDTH      BRAM port A read data (valid the cycle after address issued)
alu_a        out  DATA_WIDTH      ALU operand A
alu_b        out  DATA_WIDTH      ALU operand B
alu_opcode   out  ALU_OP_W        ALU opcode
alu_cin      out  1               ALU carry-in
alu_out      in   DATA_WIDTH      ALU result (combinational from alu_a/alu_b/opcode)
busy         out  1               high from accepted start until DONE
done         out  1               one-cycle pulse at end of sweep
error        out  1               sticky miscompare flag, cleared on accepted start
err_addr     out  ADDR_WIDTH      address of first miscompare
words_done   out  ADDR_WIDTH+1    words fully processed in current or last sweep
last_result  out  DATA_WIDTH      most recent value written to BRAM

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0, including we_a, busy, done, error, err_addr, words_done and last_result. Internal registers cleared. Reset mid-sweep drops we_a immediately. No write completes after rst_n falls.
- States: IDLE, RD, CAP, EXEC, WR, VRD, VCHK, DONE. Each word takes exactly 6 cycles (RD..VCHK).
- IDLE: start=1 latches all config inputs, sets idx=0, clears error/err_addr/words_done and sets busy=1.
  - count==0: go to DONE.
  - Otherwise: go to RD.
- RD: addr_a=cur_addr, we_a=0.
- CAP: op_reg <= q_a.
- EXEC: alu_a=op_reg, alu_b=imm_reg, alu_opcode=op_reg_sel, alu_cin=cin_reg. res_reg <= alu_out at end of cycle.
- WR: addr_a=cur_addr, data_a=res_reg, we_a=1. last_result <= res_reg.
- VRD: addr_a=cur_addr, we_a=0.
- VCHK: compare q_a with res_reg.
  - On miscompare with error==0: err_addr <= cur_addr. On any miscompare: error <= 1.
  - words_done <= idx+1.
  - stop_on_err && miscompare: go to DONE.
  - Else if idx+1==count: go to DONE.
  - Else: idx++ and go to RD.
- DONE: done=1 for exactly one cycle, busy=0 from the next cycle, then return to IDLE.
- cur_addr = (base_reg + idx) mod 2^ADDR_WIDTH. A sweep crossing the top address wraps to 0.
- count > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH.
- start while busy or in DONE: ignored, and config registers are not disturbed.
- Outside EXEC, alu_* hold their last driven values. Outside WR, we_a=0 and data_a=0.
- ALU flags are not consumed.
- Latency from start to done: 1 + 6*count + 1 cycles. With count=0: done is 2 cycles after start.

Test Plan:
- BRAM[0..3]={5,10,0xFFFF,7}, start with base=0, count=4, op=ADD (8'b00000101), imm=1 -> BRAM={6,11,0x0000,8}, done pulse at cycle 26, error=0, words_done=4, last_result=8.
- count=0 -> done 2 cycles after start, we_a never asserted, busy high for 1 cycle.
- base=0x3FE, count=3, ADD imm=2, BRAM[0x3FE,0x3FF,0x000]={1,2,3} -> writes occur at addresses 0x3FE, 0x3FF, 0x000 with values {3,4,5}.
- BRAM model corrupts the write to address 2 (stores 0x0000), count=4, stop_on_err=0 -> error=1, err_addr=2, words_done=4. Repeat with stop_on_err=1 -> done after word 2, words_done=3.
- Second start pulse in the middle of a sweep -> ignored, and the sweep finishes unchanged. rst_n low during a WR cycle -> we_a falls asynchronously, all outputs 0, and the next start runs normally.
